sar_adc_ctrl: RTL and testbench
===============================

Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller for the analog front end on the ua[] pins. It drives the sample switch and a binary-weighted capacitive DAC code, and reads back the comparator output through a synchroniser. It runs a WIDTH-bit binary search and presents the converted code to the digital outputs.

Parameters:
WIDTH, 8, DAC/result resolution in bits (legal range 2..10)
SAMPLE_CYCLES, 8, cycles sample_en is held high per conversion (legal minimum 1)
SETTLE_CYCLES, 4, cycles the DAC is allowed to settle per trial bit (legal minimum 2, covering synchroniser latency)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  enable; low aborts any conversion and holds the block in IDLE
start  input  1  conversion request, sampled only in IDLE
cont  input  1  continuous mode; when high in DONE, the next conversion starts immediately
cmp_in  input  1  raw comparator output, asynchronous; 1 means Vin >= Vdac
sample_en  output  1  closes the track/hold switch
dac_code  output  WIDTH  trial code to the DAC
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a result is updated
result  output  WIDTH  last completed conversion
result_valid  output  1  set on the first completed conversion and remains set until reset

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; synchroniser flops 0.
- cmp_in passes through a 2-flop synchroniser to give cmp_s. All decisions use cmp_s.
- State machine: IDLE, SAMPLE, SETTLE, DECIDE, DONE. All outputs are registered.
- IDLE:
  - busy=0, sample_en=0, dac_code=0.
  - If start=1 and ena=1 at an edge, go to SAMPLE. Call that cycle c0.
- SAMPLE:
  - sample_en=1 and dac_code=0 for exactly SAMPLE_CYCLES cycles.
  - Then load bit index k=WIDTH-1 and dac_code = 1<<k, and go to SETTLE.
- SETTLE:
  - Hold dac_code for exactly SETTLE_CYCLES cycles, then go to DECIDE.
- DECIDE (1 cycle):
  - If cmp_s=0, clear bit k of dac_code; if cmp_s=1, keep it.
  - If k>0: set bit k-1, decrement k, go to SETTLE.
  - If k=0: go to DONE, registering result <= final code and result_valid <= 1 on that edge.
- DONE (1 cycle):
  - done=1, busy=1, and dac_code keeps the final code.
  - Next state is SAMPLE (counter reloaded, dac_code=0) if cont=1 and ena=1; otherwise IDLE.
- Latency: done is high in cycle c0 + SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1. With the defaults this is c0+49.
- A conversion period in continuous mode is SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1 cycles; 49 with the defaults.
- start while busy is ignored and not queued. start held high in IDLE starts a new conversion on every return to IDLE.
- ena low in any non-IDLE state: next edge goes to IDLE. The conversion is discarded; result, result_valid and done are unchanged; dac_code and sample_en go to 0.
- rst_n low mid-conversion: everything clears immediately to its reset values, including result and result_valid.
- Counters are sized for their maximum value with no wrap. The bit index never underflows because the k=0 case exits to DONE.
- done and the result update coincide (same edge). result is stable at all other times.

Test Plan:
- Bench model: cmp_in = (vin_code >= dac_code), combinational from dac_code.
- Defaults, vin=0xA5, start pulse at c0 -> dac_code trial sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done only in c0+49; result=0xA5; result_valid=1.
- vin=0x00, then vin=0xFF (separate conversions) -> result 0x00 and 0xFF respectively; sample_en high for exactly 8 cycles each time.
- start pulsed at c0+10 during a conversion with vin=0x3C -> ignored; exactly one done at c0+49; result=0x3C.
- Complete vin=0x55, then start a new conversion and drop ena at c0+20 -> IDLE at the next edge, busy=0, dac_code=0, no done, result remains 0x55.
- cont=1, vin changed to 0x12, 0x34, 0x56 between conversions -> done pulses 49 cycles apart, results 0x12, 0x34, 0x56, with sample_en re-asserted the cycle after each done.
- rst_n asserted asynchronously mid-SETTLE -> all outputs 0 immediately (before the next edge); result_valid=0; next start converts normally.

Source files
------------

// File: rtl/sar_adc_ctrl_if.sv
// Analog-front-end handshake bundle for the SAR controller: control inputs,
// raw comparator input and registered conversion outputs.
interface sar_adc_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic             start;
  logic             cont;
  logic             cmp_in;
  logic             sample_en;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  modport master (
    output ena, start, cont, cmp_in,
    input  sample_en, dac_code, busy, done, result, result_valid
  );

  modport slave (
    input  ena, start, cont, cmp_in,
    output sample_en, dac_code, busy, done, result, result_valid
  );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: samples, then runs a WIDTH-bit
// binary search against a synchronised comparator and publishes the code.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sar_adc_ctrl_if.slave   bus
);
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int K_W     = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST      = K_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, DECIDE, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             sample_en_q, sample_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sync1_q, cmp_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      cmp_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.cmp_in;
      cmp_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      code_q      <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      code_q      <= code_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    code_d   = code_q;
    result_d = result_q;
    valid_d  = valid_q;
    // Dropping ena abandons the conversion without touching the last result.
    if (state_q != IDLE && !bus.ena) begin
      state_d = IDLE;
      code_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && bus.ena) begin
            state_d = SAMPLE;
            cnt_d   = SAMPLE_LOAD;
            code_d  = '0;
          end
        end
        SAMPLE: begin
          if (cnt_q == '0) begin
            state_d           = SETTLE;
            cnt_d             = SETTLE_LOAD;
            k_d               = K_LAST;
            code_d            = '0;
            code_d[WIDTH-1]   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_d = DECIDE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        DECIDE: begin
          if (!cmp_s_q) code_d[k_q] = 1'b0;
          if (k_q != '0) begin
            code_d[k_q - 1'b1] = 1'b1;
            k_d                = k_q - 1'b1;
            cnt_d              = SETTLE_LOAD;
            state_d            = SETTLE;
          end else begin
            state_d  = DONE;
            result_d = code_d;
            valid_d  = 1'b1;
          end
        end
        DONE: begin
          code_d = '0;
          if (bus.cont && bus.ena) begin
            state_d = SAMPLE;
            cnt_d   = SAMPLE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = '0;
        end
      endcase
    end
  end

  // Flag outputs are decoded from the next state so they land in flops.
  always_comb begin
    sample_en_d = (state_d == SAMPLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  assign bus.sample_en    = sample_en_q;
  assign bus.dac_code     = code_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal comparator model driven from
// the DAC code.
module tb_sar_adc_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] vin_code;

  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.WIDTH(W)) bus ();

  assign bus.cmp_in = (vin_code >= bus.dac_code);

  sar_adc_ctrl #(
    .WIDTH(W),
    .SAMPLE_CYCLES(8),
    .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One conversion from a start pulse; cycle index cyc counts from c0.
  task automatic run_conv(input logic [7:0] vin, input logic [7:0] exp_res,
                          input int start_at, input int ena_drop_at, input bit chk_seq);
    int done_cnt = 0;
    int done_cyc = -1;
    int se_cnt   = 0;
    logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    vin_code  = vin;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_dac_hold", bus.dac_code, exp_res);
      end
      if (bus.sample_en) se_cnt++;
      if (chk_seq && cyc >= 9 && cyc <= 44 && ((cyc - 9) % 5) == 0)
        chk("trial_code", bus.dac_code, seq[(cyc - 9) / 5]);
      if (ena_drop_at > 0 && cyc == ena_drop_at + 1) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_dac", bus.dac_code, 0);
        chk("abort_sample_en", bus.sample_en, 0);
        bus.ena = 1'b1;
      end
      if (cyc == start_at)    bus.start = 1'b1;
      if (cyc == ena_drop_at) bus.ena   = 1'b0;
      tick;
      bus.start = 1'b0;
    end
    if (ena_drop_at > 0) begin
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_result", bus.result, exp_res);
      chk("abort_valid", bus.result_valid, 1);
    end else begin
      chk("done_cnt", done_cnt, 1);
      chk("done_cycle", done_cyc, 49);
      chk("sample_cycles", se_cnt, 8);
      chk("result", bus.result, exp_res);
      chk("result_valid", bus.result_valid, 1);
    end
  endtask

  task automatic run_cont;
    int idx = 0;
    bit se_pending = 1'b0;
    logic [7:0] vins [3] = '{8'h12, 8'h34, 8'h56};
    vin_code  = vins[0];
    bus.cont  = 1'b1;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 155; cyc++) begin
      if (se_pending) begin
        chk("cont_sample_en", bus.sample_en, 1);
        se_pending = 1'b0;
      end
      if (bus.done) begin
        if (idx < 3) begin
          chk("cont_result", bus.result, vins[idx]);
          chk("cont_done_cycle", cyc, 49 * (idx + 1));
        end
        idx++;
        if (idx < 3) begin
          vin_code   = vins[idx];
          se_pending = 1'b1;
        end
      end
      if (cyc == 100) bus.cont = 1'b0;
      tick;
    end
    chk("cont_done_cnt", idx, 3);
    chk("cont_idle_busy", bus.busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.cont  = 1'b0;
    vin_code  = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_dac", bus.dac_code, 0);
    chk("rst_sample_en", bus.sample_en, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.result_valid, 0);
    rst_n = 1'b1;
    tick;
    tick;

    run_conv(8'hA5, 8'hA5, 0, 0, 1'b1);
    run_conv(8'h00, 8'h00, 0, 0, 1'b0);
    run_conv(8'hFF, 8'hFF, 0, 0, 1'b0);
    run_conv(8'h3C, 8'h3C, 10, 0, 1'b0);
    run_conv(8'h55, 8'h55, 0, 0, 1'b0);
    run_conv(8'h99, 8'h55, 0, 20, 1'b0);
    run_cont;

    vin_code  = 8'h77;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 1; i < 15; i++) tick;
    chk("pre_reset_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_dac", bus.dac_code, 0);
    chk("async_rst_sample_en", bus.sample_en, 0);
    chk("async_rst_done", bus.done, 0);
    chk("async_rst_result", bus.result, 0);
    chk("async_rst_valid", bus.result_valid, 0);
    #1;
    rst_n = 1'b1;
    tick;
    run_conv(8'hA5, 8'hA5, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
